// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/stall sequencer.
// Holds the FSM state encoding, the register specifier width and the stats counter widths.
package hazard_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  localparam int STALL_CNT_W = 32;
  localparam int FLUSH_CNT_W = 16;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_WAIT = 2'd1,
    MD_DONE = 2'd2
  } hz_state_e;

endpackage

// File: rtl/hazard_load_use_detect.sv
// Load-use compare between the load in EX and the source operands of the instruction in ID.
// Purely combinational (zero latency); the caller decides when the result is honoured.
module hazard_load_use_detect
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = hazard_pkg::REG_ADDR_W
) (
  input  logic                  mem_read_ex,
  input  logic [REG_ADDR_W-1:0] rt_ex,
  input  logic [REG_ADDR_W-1:0] rs_id,
  input  logic [REG_ADDR_W-1:0] rt_id,
  input  logic                  uses_rt_id,
  output logic                  hazard
);

  logic dest_nonzero;
  logic rs_match;
  logic rt_match;

  always_comb begin
    // $zero is hardwired, so a load targeting it never produces a dependency
    dest_nonzero = (rt_ex != REG_ADDR_W'(ZERO_REG));
    rs_match     = (rt_ex == rs_id);
    rt_match     = uses_rt_id && (rt_ex == rt_id);
    hazard       = mem_read_ex && dest_nonzero && (rs_match || rt_match);
  end

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush sequencer: load-use bubble, taken-branch flush, front-end freeze during mul/div.
// Mealy outputs (same-cycle effect); optional stats counters under HAZARD_STATS_EN.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int MULDIV_CYCLES = 4,
  parameter int REG_ADDR_W    = hazard_pkg::REG_ADDR_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  memReadIDEX,
  input  logic [REG_ADDR_W-1:0] rtIDEX,
  input  logic [REG_ADDR_W-1:0] rsIFID,
  input  logic [REG_ADDR_W-1:0] rtIFID,
  input  logic                  usesRtIFID,
  input  logic                  branchTaken,
  input  logic                  mdStartIDEX,
  output logic                  pcWrite,
  output logic                  ifidWrite,
  output logic                  idexWrite,
  output logic                  idexBubble,
  output logic                  exmemBubble,
  output logic                  ifidFlush,
  output logic                  mdStart,
  output logic                  mdBusy
`ifdef HAZARD_STATS_EN
  ,
  output logic [STALL_CNT_W-1:0] stallCycles,
  output logic [FLUSH_CNT_W-1:0] flushCount
`endif
);

  localparam int CNT_W = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use;
  logic             flush_accept;

  hazard_load_use_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_load_use (
    .mem_read_ex (memReadIDEX),
    .rt_ex       (rtIDEX),
    .rs_id       (rsIFID),
    .rt_id       (rtIFID),
    .uses_rt_id  (usesRtIFID),
    .hazard      (load_use)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pcWrite      = 1'b1;
    ifidWrite    = 1'b1;
    idexWrite    = 1'b1;
    idexBubble   = 1'b0;
    exmemBubble  = 1'b0;
    ifidFlush    = 1'b0;
    mdStart      = 1'b0;
    mdBusy       = 1'b0;
    flush_accept = 1'b0;

    if (reset) begin
      pcWrite    = 1'b0;
      ifidWrite  = 1'b0;
      idexWrite  = 1'b0;
      idexBubble = 1'b1;
      state_d    = RUN;
      cnt_d      = '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (branchTaken) begin
            ifidFlush    = 1'b1;
            idexBubble   = 1'b1;
            pcWrite      = 1'b1;
            flush_accept = 1'b1;
          end else if (mdStartIDEX) begin
            mdStart     = 1'b1;
            pcWrite     = 1'b0;
            ifidWrite   = 1'b0;
            idexWrite   = 1'b0;
            exmemBubble = 1'b1;
            cnt_d       = CNT_LOAD;
            state_d     = MD_WAIT;
          end else if (load_use) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            idexBubble = 1'b1;
          end
        end

        MD_WAIT: begin
          mdBusy      = 1'b1;
          pcWrite     = 1'b0;
          ifidWrite   = 1'b0;
          idexWrite   = 1'b0;
          exmemBubble = 1'b1;
          if (cnt_q == '0) begin
            state_d = MD_DONE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end

        MD_DONE: begin
          // The finished mul/div is still in ID/EX, so mdStartIDEX must not retrigger here
          state_d = RUN;
          if (load_use) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            idexBubble = 1'b1;
          end
        end

        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [STALL_CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [FLUSH_CNT_W-1:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    // Both counters saturate rather than wrap
    if (!pcWrite && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + STALL_CNT_W'(1);
    end
    if (flush_accept && (flush_count_q != '1)) begin
      flush_count_d = flush_count_q + FLUSH_CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stallCycles = stall_cycles_q;
  assign flushCount  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller (MULDIV_CYCLES = 4); checks stats when HAZARD_STATS_EN is defined.
module tb_hazard_controller;

  logic       clock;
  logic       reset;
  logic       memReadIDEX;
  logic [4:0] rtIDEX;
  logic [4:0] rsIFID;
  logic [4:0] rtIFID;
  logic       usesRtIFID;
  logic       branchTaken;
  logic       mdStartIDEX;
  logic       pcWrite;
  logic       ifidWrite;
  logic       idexWrite;
  logic       idexBubble;
  logic       exmemBubble;
  logic       ifidFlush;
  logic       mdStart;
  logic       mdBusy;
`ifdef HAZARD_STATS_EN
  logic [31:0] stallCycles;
  logic [15:0] flushCount;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  hazard_controller #(
    .MULDIV_CYCLES (4),
    .REG_ADDR_W    (5)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .memReadIDEX (memReadIDEX),
    .rtIDEX      (rtIDEX),
    .rsIFID      (rsIFID),
    .rtIFID      (rtIFID),
    .usesRtIFID  (usesRtIFID),
    .branchTaken (branchTaken),
    .mdStartIDEX (mdStartIDEX),
    .pcWrite     (pcWrite),
    .ifidWrite   (ifidWrite),
    .idexWrite   (idexWrite),
    .idexBubble  (idexBubble),
    .exmemBubble (exmemBubble),
    .ifidFlush   (ifidFlush),
    .mdStart     (mdStart),
    .mdBusy      (mdBusy)
`ifdef HAZARD_STATS_EN
    ,
    .stallCycles (stallCycles),
    .flushCount  (flushCount)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic probe();
    @(negedge clock);
  endtask

  task automatic idle();
    memReadIDEX = 1'b0;
    rtIDEX      = 5'd0;
    rsIFID      = 5'd0;
    rtIFID      = 5'd0;
    usesRtIFID  = 1'b0;
    branchTaken = 1'b0;
    mdStartIDEX = 1'b0;
  endtask

  // bit i = expected value in the i-th cycle of a mul/div sequence (mdStart cycle is 0)
  logic [5:0] exp_start;
  logic [5:0] exp_busy;
  logic [5:0] exp_pcw;
  logic [5:0] exp_exb;
  int         busy_cnt;

  initial begin
    exp_start = 6'b000001;
    exp_busy  = 6'b011110;
    exp_pcw   = 6'b100000;
    exp_exb   = 6'b011111;

    idle();
    reset = 1'b1;
    probe();
    chk("rst_pcWrite",    pcWrite,    0);
    chk("rst_ifidWrite",  ifidWrite,  0);
    chk("rst_idexWrite",  idexWrite,  0);
    chk("rst_idexBubble", idexBubble, 1);
    chk("rst_mdBusy",     mdBusy,     0);
    chk("rst_ifidFlush",  ifidFlush,  0);
    step();
    reset = 1'b0;
    probe();
    chk("def_pcWrite",    pcWrite,    1);
    chk("def_idexWrite",  idexWrite,  1);
    chk("def_idexBubble", idexBubble, 0);
`ifdef HAZARD_STATS_EN
    chk("rst_stall",      stallCycles, 0);
    chk("rst_flush",      flushCount,  0);
`endif
    step();

    // Load-use on rs: one stall cycle, then defaults
    memReadIDEX = 1'b1; rtIDEX = 5'd8; rsIFID = 5'd8;
    probe();
    chk("lu_pcWrite",    pcWrite,    0);
    chk("lu_ifidWrite",  ifidWrite,  0);
    chk("lu_idexBubble", idexBubble, 1);
    chk("lu_idexWrite",  idexWrite,  1);
    step();
    idle();
    probe();
    chk("lu_after_pcWrite",    pcWrite,    1);
    chk("lu_after_idexBubble", idexBubble, 0);
    step();

    // Register 0 destination never stalls
    memReadIDEX = 1'b1; rtIDEX = 5'd0; rsIFID = 5'd0;
    probe();
    chk("zero_pcWrite", pcWrite, 1);
    step();

    // rt match only counts when the ID instruction reads rt
    rtIDEX = 5'd8; rsIFID = 5'd3; rtIFID = 5'd8; usesRtIFID = 1'b0;
    probe();
    chk("nouse_rt_pcWrite", pcWrite, 1);
    step();
    usesRtIFID = 1'b1;
    probe();
    chk("use_rt_pcWrite",    pcWrite,    0);
    chk("use_rt_idexBubble", idexBubble, 1);
    step();

    // Branch beats a simultaneous load-use
    branchTaken = 1'b1;
    probe();
    chk("br_lu_ifidFlush",  ifidFlush,  1);
    chk("br_lu_idexBubble", idexBubble, 1);
    chk("br_lu_pcWrite",    pcWrite,    1);
    chk("br_lu_ifidWrite",  ifidWrite,  1);
    step();

    // Branch beats a simultaneous mul/div start
    idle();
    branchTaken = 1'b1; mdStartIDEX = 1'b1;
    probe();
    chk("br_md_mdStart",   mdStart,   0);
    chk("br_md_ifidFlush", ifidFlush, 1);
    chk("br_md_pcWrite",   pcWrite,   1);
    step();
    idle();
    probe();
    chk("br_md_after_mdBusy", mdBusy, 0);
    step();

    // Third load-use stall
    memReadIDEX = 1'b1; rtIDEX = 5'd9; rsIFID = 5'd9;
    probe();
    chk("lu3_pcWrite", pcWrite, 0);
    step();
    idle();

    // Mul/div with mdStartIDEX held through MD_DONE
    mdStartIDEX = 1'b1;
    for (int i = 0; i < 6; i++) begin
      probe();
      chk($sformatf("md%0d_mdStart", i),     mdStart,     exp_start[i]);
      chk($sformatf("md%0d_mdBusy", i),      mdBusy,      exp_busy[i]);
      chk($sformatf("md%0d_pcWrite", i),     pcWrite,     exp_pcw[i]);
      chk($sformatf("md%0d_exmemBubble", i), exmemBubble, exp_exb[i]);
      step();
    end
    idle();
    probe();
    chk("md_after_mdStart", mdStart, 0);
    chk("md_after_pcWrite", pcWrite, 1);
`ifdef HAZARD_STATS_EN
    chk("stats_stall", stallCycles, 8);
    chk("stats_flush", flushCount,  2);
`endif
    step();

    // Reset in the second MD_WAIT cycle aborts the wait
    mdStartIDEX = 1'b1;
    probe();
    chk("mr_mdStart", mdStart, 1);
    step();
    mdStartIDEX = 1'b0;
    probe();
    chk("mr_wait1_mdBusy", mdBusy, 1);
    step();
    reset = 1'b1;
    probe();
    chk("mr_rst_mdBusy",     mdBusy,     0);
    chk("mr_rst_pcWrite",    pcWrite,    0);
    chk("mr_rst_idexBubble", idexBubble, 1);
    step();
    reset = 1'b0;
    probe();
    chk("mr_run_mdBusy",  mdBusy,  0);
    chk("mr_run_pcWrite", pcWrite, 1);
`ifdef HAZARD_STATS_EN
    chk("mr_stall_clr", stallCycles, 0);
    chk("mr_flush_clr", flushCount,  0);
`endif
    step();

    // Fresh mul/div after the abort still waits the full four cycles
    mdStartIDEX = 1'b1;
    step();
    mdStartIDEX = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      probe();
      busy_cnt += int'(mdBusy);
      step();
    end
    chk("mr_refill_busy_cycles", busy_cnt, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
